spmmio_spi_fifo: RTL and testbench

SPMMIO_SPI_FIFO -- requirements
Module: spmmio_spi_fifo

---
 rtl/spmmio_spi_fifo.sv | 253 +++++++++++++++++++++++++
 tb/tb_spmmio_spi_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmmio_spi_fifo.sv
// rtl/spmmio_spi_fifo.sv - Memory-mapped SPI master with byte-wide TX and RX FIFOs
//
// Purpose: four 32-bit registers (CTRL, CS, STATUS, DATA) in front of an SPI
// master engine. Bytes written to DATA queue in the TX FIFO, are shifted out
// MSB-first in any of the four SPI modes, and the bytes received in exchange
// queue in the RX FIFO for the bus to pop.
//
// Ports:
//   clk, reset_n         clock; synchronous active-low reset
//   adr [0:3]            register index (0 CTRL, 1 CS, 2 STATUS, 3 DATA)
//   cs, we, sel [0:3]    bus select, write strobe, byte lanes (sel[3] = d[24:31])
//   d [0:31], q [0:31]   write data / combinational read data, bit 0 is the MSB
//   spi_cs [NCS-1:0]     chip selects, active high, straight from the CS mask
//   spi_sck, spi_mosi    serial clock and data out
//   spi_miso             serial data in, asynchronous to clk
module spmmio_spi_fifo #(
  parameter int NCS   = 1,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [0:3]     adr,
  input  logic           cs,
  input  logic [0:3]     sel,
  input  logic           we,
  input  logic [0:31]    d,
  output logic [0:31]    q,
  output logic [NCS-1:0] spi_cs,
  output logic           spi_sck,
  input  logic           spi_miso,
  output logic           spi_mosi
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LV_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  // Control / status registers
  logic [7:0]     r_div;
  logic           r_cpol;
  logic           r_cpha;
  logic [NCS-1:0] r_csm;
  logic           r_ovf;

  // FIFOs
  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp;
  logic [CW-1:0] r_tx_cnt;
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_rx_cnt;

  // Engine
  state_t     r_state;
  logic [7:0] r_div_l;
  logic       r_cpha_l;
  logic [7:0] r_cnt;
  logic [3:0] r_half;
  logic [7:0] r_tx_sh;
  logic [7:0] r_rx_sh;
  logic       r_mosi;
  logic       r_sck;
  logic       r_miso_s;

  // Bus decode
  logic       w_wr, w_rd;
  logic       w_tx_flush, w_rx_flush;
  logic       w_tx_push_req, w_tx_push;
  logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic       w_start, w_rx_push, w_rx_pop, w_busy;
  logic [7:0] w_tx_head, w_rx_head;

  assign w_wr          = cs && we;
  assign w_rd          = cs && !we;
  assign w_tx_flush    = w_wr && (adr == 4'd0) && sel[3] && d[30];
  assign w_rx_flush    = w_wr && (adr == 4'd0) && sel[3] && d[31];
  assign w_tx_push_req = w_wr && (adr == 4'd3) && sel[3];

  assign w_tx_full  = (r_tx_cnt == LV_FULL);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == LV_FULL);
  assign w_rx_empty = (r_rx_cnt == '0);

  assign w_tx_push = w_tx_push_req && !w_tx_full;
  // Starting only when RX has room guarantees the byte in flight always has
  // a slot to land in. A TX flush in the same cycle wins over the start.
  assign w_start   = (r_state == S_IDLE) && !w_tx_empty && !w_rx_full && !w_tx_flush;
  assign w_rx_push = (r_state == S_DONE);
  assign w_rx_pop  = w_rd && (adr == 4'd3) && sel[3] && !w_rx_empty;
  assign w_busy    = (r_state != S_IDLE) || !w_tx_empty;

  assign w_tx_head = r_tx_mem[r_tx_rp];
  assign w_rx_head = r_rx_mem[r_rx_rp];

  // Read mux
  always_comb begin
    q = '0;
    case (adr)
      4'd0: begin
        q[16:23] = r_div;
        q[26]    = r_cpol;
        q[27]    = r_cpha;
      end
      4'd1: begin
        for (int i = 0; i < NCS; i++) q[24+i] = r_csm[i];
      end
      4'd2: begin
        q[24]    = w_busy;
        q[25]    = w_tx_full;
        q[26]    = w_tx_empty;
        q[27]    = w_rx_full;
        q[28]    = w_rx_empty;
        q[29]    = r_ovf;
        q[16:20] = 5'(r_tx_cnt);
        q[8:12]  = 5'(r_rx_cnt);
      end
      4'd3: begin
        if (!w_rx_empty) begin
          q[23]    = 1'b1;
          q[24:31] = w_rx_head;
        end
      end
      default: q = '0;
    endcase
  end

  // CTRL, CS and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div  <= 8'hFF;
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_csm  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr && (adr == 4'd0)) begin
        if (sel[2]) r_div <= d[16:23];
        if (sel[3]) begin
          r_cpol <= d[26];
          r_cpha <= d[27];
        end
      end
      if (w_wr && (adr == 4'd1) && sel[3]) begin
        for (int i = 0; i < NCS; i++) r_csm[i] <= d[24+i];
      end
      if (w_tx_flush)
        r_ovf <= 1'b0;
      else if (w_tx_push_req && w_tx_full)
        r_ovf <= 1'b1;
      else if (w_wr && (adr == 4'd2) && sel[3] && d[29])
        r_ovf <= 1'b0;
    end
  end

  // TX FIFO: bus pushes, engine pops when a byte starts
  always_ff @(posedge clk) begin
    if (!reset_n || w_tx_flush) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wp] <= d[24:31];
        r_tx_wp           <= r_tx_wp + AW'(1);
      end
      if (w_start) r_tx_rp <= r_tx_rp + AW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_start);
    end
  end

  // RX FIFO: engine pushes in DONE, bus pops; a flush discards a same-cycle push
  always_ff @(posedge clk) begin
    if (!reset_n || w_rx_flush) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wp] <= r_rx_sh;
        r_rx_wp           <= r_rx_wp + AW'(1);
      end
      if (w_rx_pop) r_rx_rp <= r_rx_rp + AW'(1);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end

  // Engine. Half-period h is leading when h is even. Sampling happens on the
  // edge whose parity equals cpha; shifting happens on the other one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_div_l  <= 8'd0;
      r_cpha_l <= 1'b0;
      r_cnt    <= 8'd0;
      r_half   <= 4'd0;
      r_tx_sh  <= 8'd0;
      r_rx_sh  <= 8'd0;
      r_mosi   <= 1'b0;
      r_sck    <= 1'b0;
      r_miso_s <= 1'b0;
    end else begin
      r_miso_s <= spi_miso;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_LOAD;
            r_div_l  <= r_div;
            r_cpha_l <= r_cpha;
            r_sck    <= r_cpol;
            r_cnt    <= 8'd0;
            r_half   <= 4'd0;
            if (r_cpha) begin
              // First bit is presented on the first leading edge.
              r_mosi  <= 1'b0;
              r_tx_sh <= w_tx_head;
            end else begin
              r_mosi  <= w_tx_head[7];
              r_tx_sh <= {w_tx_head[6:0], 1'b0};
            end
          end
        end
        S_LOAD: r_state <= S_SHIFT;
        S_SHIFT: begin
          if (r_cnt == r_div_l) begin
            r_cnt  <= 8'd0;
            r_sck  <= ~r_sck;
            r_half <= r_half + 4'd1;
            if (r_half[0] == r_cpha_l) begin
              r_rx_sh <= {r_rx_sh[6:0], r_miso_s};
            end else begin
              r_mosi  <= r_tx_sh[7];
              r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            end
            if (r_half == 4'd15) r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // In IDLE the clock follows the live CPOL; during a byte it follows the
  // value latched at start, which 16 toggles return to by DONE.
  assign spi_sck  = (r_state == S_IDLE) ? r_cpol : r_sck;
  assign spi_mosi = ((r_state == S_LOAD) || (r_state == S_SHIFT)) ? r_mosi : 1'b0;
  assign spi_cs   = r_csm;

endmodule

// File: tb/tb_spmmio_spi_fifo.sv
// tb/tb_spmmio_spi_fifo.sv - Self-checking bench for spmmio_spi_fifo
module tb_spmmio_spi_fifo;
  localparam int NCS   = 2;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [0:3]     adr = '0;
  logic           cs = 1'b0;
  logic [0:3]     sel = '0;
  logic           we = 1'b0;
  logic [0:31]    d = '0;
  logic [0:31]    q;
  logic [NCS-1:0] spi_cs;
  logic           spi_sck, spi_miso, spi_mosi;
  logic           loop_en = 1'b1;
  logic           slave_miso = 1'b0;

  assign spi_miso = loop_en ? spi_mosi : slave_miso;

  always #5 clk = ~clk;

  spmmio_spi_fifo #(.NCS(NCS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .adr(adr), .cs(cs), .sel(sel), .we(we),
    .d(d), .q(q), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_miso(spi_miso),
    .spi_mosi(spi_mosi)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [3:0] s, input logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; adr = a; sel = s; d = v;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; sel = '0; d = '0;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [3:0] s, output logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; adr = a; sel = s;
    #1 v = q;
    @(negedge clk);
    cs = 1'b0; sel = '0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    adr = a;
    #1 v = q;
  endtask

  // Returns the cycles waited until RX is non-empty, or -1 on timeout.
  task automatic wait_rx(input int budget, output int cyc);
    cyc = 0;
    adr = 4'd2;
    while (cyc < budget) begin
      @(negedge clk);
      #1 cyc++;
      if (!q[28]) return;
    end
    cyc = -1;
  endtask

  // Reference model for the random phase: with MOSI looped to MISO every
  // accepted byte comes back unchanged and in order.
  logic [7:0] exp_q[$];

  task automatic try_pop();
    logic [31:0] v;
    logic [7:0]  e;
    bus_rd(4'd3, 4'b0001, v);
    if (v[8]) begin
      if (exp_q.size() == 0) begin
        check("rand unexpected byte", v, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("rand data", v, {23'd0, 1'b1, e});
      end
    end
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  s;
    logic [31:0] v;
    logic [31:0] exp;
    logic [1:0]  exp_cs;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [31:0] v;
    int          cyc, rises, falls, edges, bad, sidx;
    logic        prev_sck, prev_mosi, fell, rose;
    logic [7:0]  mcap, sbyte, b;
    logic        ok;

    // Register write/read vectors: write record, then read same address.
    vt[0]  = '{4'd0, 4'b0011, 32'h0000_1230, 32'h0000_1230, 2'b00};
    vt[1]  = '{4'd0, 4'b0010, 32'h0000_5600, 32'h0000_5630, 2'b00};
    vt[2]  = '{4'd0, 4'b0001, 32'h0000_0000, 32'h0000_5600, 2'b00};
    vt[3]  = '{4'd0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_5600, 2'b00};
    vt[4]  = '{4'd0, 4'b0001, 32'h0000_0033, 32'h0000_5630, 2'b00};
    vt[5]  = '{4'd0, 4'b0001, 32'h0000_0000, 32'h0000_5600, 2'b00};
    vt[6]  = '{4'd1, 4'b0001, 32'h0000_00FF, 32'h0000_00C0, 2'b11};
    vt[7]  = '{4'd1, 4'b0001, 32'h0000_0040, 32'h0000_0040, 2'b10};
    vt[8]  = '{4'd1, 4'b0001, 32'h0000_0080, 32'h0000_0080, 2'b01};
    vt[9]  = '{4'd1, 4'b1110, 32'h0000_0000, 32'h0000_0080, 2'b01};
    vt[10] = '{4'd2, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0028, 2'b01};
    vt[11] = '{4'd5, 4'b1111, 32'h0000_0123, 32'h0000_0000, 2'b01};
    vt[12] = '{4'd1, 4'b0001, 32'h0000_003F, 32'h0000_0000, 2'b00};

    // Reset: writes during reset are ignored
    repeat (2) @(negedge clk);
    bus_wr(4'd0, 4'b1111, 32'h0000_1234);
    bus_wr(4'd1, 4'b0001, 32'h0000_00FF);
    bus_wr(4'd3, 4'b0001, 32'h0000_0055);
    peek(4'd0, v); check("reset ctrl", v, 32'h0000_FF00);
    peek(4'd1, v); check("reset cs reg", v, 32'h0);
    peek(4'd2, v); check("reset status", v, 32'h0000_0028);
    check("reset pins", {spi_cs, spi_sck, spi_mosi}, 32'h0);
    @(negedge clk) reset_n = 1'b1;

    // Table-driven register checks
    for (int i = 0; i < 13; i++) begin
      bus_wr(vt[i].a, vt[i].s, vt[i].v);
      peek(vt[i].a, v);
      check($sformatf("vec%0d read", i), v, vt[i].exp);
      check($sformatf("vec%0d spi_cs", i), {30'd0, spi_cs}, {30'd0, vt[i].exp_cs});
    end

    // Mode 0 loopback, divider 1
    bus_wr(4'd0, 4'b0011, 32'h0000_0100);
    loop_en = 1'b1;
    bus_wr(4'd3, 4'b0001, 32'h0000_00A5);
    adr = 4'd2; prev_sck = spi_sck; rises = 0; cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      #1 cyc++;
      if (!prev_sck && spi_sck) rises++;
      prev_sck = spi_sck;
      if (!q[28]) break;
    end
    check("m0 latency", cyc, 35);
    check("m0 sck rises", rises, 8);
    check("m0 busy fell", {31'd0, q[24]}, 32'h0);
    bus_rd(4'd3, 4'b0001, v); check("m0 rx", v, 32'h0000_01A5);
    peek(4'd2, v); check("m0 status after pop", v, 32'h0000_0028);

    // Mode 3 with an external slave returning 0x3C
    bus_wr(4'd0, 4'b0011, 32'h0000_0230);
    loop_en = 1'b0;
    peek(4'd2, v);
    check("m3 sck idle high", {31'd0, spi_sck}, 32'h1);
    sbyte = 8'h3C;
    bus_wr(4'd3, 4'b0001, 32'h0000_003C);
    adr = 4'd2; prev_sck = spi_sck; prev_mosi = spi_mosi;
    cyc = 0; edges = 0; bad = 0; falls = 0; sidx = 0; mcap = 8'h00; ok = 1'b0;
    while (cyc < 400) begin
      @(negedge clk);
      #1 cyc++;
      fell = prev_sck && !spi_sck;
      rose = !prev_sck && spi_sck;
      if ((spi_mosi !== prev_mosi) && !fell && (edges < 15)) bad++;
      if (fell) begin
        falls++;
        if (sidx < 8) begin
          slave_miso = sbyte[3'(7 - sidx)];
          sidx++;
        end
      end
      if (rose) mcap = {mcap[6:0], prev_mosi};
      if (fell || rose) edges++;
      prev_sck = spi_sck;
      prev_mosi = spi_mosi;
      if (!q[28]) begin ok = 1'b1; break; end
    end
    check("m3 done", {31'd0, ok}, 32'h1);
    check("m3 mosi only on falling", bad, 0);
    check("m3 falls", falls, 8);
    check("m3 mosi byte", {24'd0, mcap}, 32'h3C);
    check("m3 sck back high", {31'd0, spi_sck}, 32'h1);
    bus_rd(4'd3, 4'b0001, v); check("m3 rx", v, 32'h0000_013C);
    loop_en = 1'b1;

    // Overflow, W1C, TX flush with a byte in flight
    bus_wr(4'd0, 4'b0011, 32'h0000_FF00);
    for (int i = 0; i < 6; i++) bus_wr(4'd3, 4'b0001, 32'h10 + i);
    peek(4'd2, v); check("ovf status", v, 32'h0000_20CC);
    bus_wr(4'd2, 4'b0001, 32'h0000_0004);
    peek(4'd2, v); check("ovf w1c", v, 32'h0000_20C8);
    bus_wr(4'd3, 4'b0001, 32'h0000_0099);
    peek(4'd2, v); check("ovf again", v, 32'h0000_20CC);
    bus_wr(4'd0, 4'b0011, 32'h0000_FF02);
    peek(4'd2, v); check("tx flush status", v, 32'h0000_00A8);
    wait_rx(4400, cyc);
    check("flush inflight done", {31'd0, cyc > 0}, 32'h1);
    peek(4'd2, v); check("flush inflight status", v, 32'h0008_0020);
    bus_rd(4'd3, 4'b0001, v); check("flush inflight rx", v, 32'h0000_0110);

    // Reset in the middle of a byte
    bus_wr(4'd0, 4'b0011, 32'h0000_0300);
    bus_wr(4'd1, 4'b0001, 32'h0000_0040);
    bus_wr(4'd3, 4'b0001, 32'h0000_0011);
    wait_rx(200, cyc);
    check("pre-reset byte done", {31'd0, cyc > 0}, 32'h1);
    bus_wr(4'd3, 4'b0001, 32'h0000_00FF);
    repeat (20) @(negedge clk);
    #1 check("pre-reset mosi", {31'd0, spi_mosi}, 32'h1);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk);
    #1 check("rst pins", {28'd0, spi_cs, spi_sck, spi_mosi}, 32'h0);
    adr = 4'd2; #1 check("rst status", q, 32'h0000_0028);
    adr = 4'd0; #1 check("rst ctrl", q, 32'h0000_FF00);
    @(negedge clk) reset_n = 1'b1;

    // RX-full stall
    bus_wr(4'd0, 4'b0011, 32'h0000_0100);
    for (int i = 0; i < DEPTH + 2; i++) begin
      cyc = 0;
      do begin peek(4'd2, v); cyc++; end while (v[6] && cyc < 300);
      bus_wr(4'd3, 4'b0001, 32'h60 + i);
    end
    repeat (400) @(negedge clk);
    peek(4'd2, v); check("stall status", v, 32'h0020_1090);
    bus_rd(4'd3, 4'b0001, v); check("stall pop", v, 32'h0000_0160);
    repeat (200) @(negedge clk);
    peek(4'd2, v); check("stall one more", v, 32'h0020_0890);
    bus_wr(4'd0, 4'b0011, 32'h0000_0101);
    peek(4'd2, v); check("rx flush", v & 32'h00F8_0018, 32'h0000_0008);
    wait_rx(200, cyc);
    check("after flush byte done", {31'd0, cyc > 0}, 32'h1);
    bus_rd(4'd3, 4'b0001, v); check("after flush rx", v, 32'h0000_0165);
    peek(4'd2, v); check("stall end status", v, 32'h0000_0028);

    // Randomised loopback against the queue model
    for (int r = 0; r < 4; r++) begin
      bus_wr(4'd0, 4'b0011, ($urandom_range(1, 3) << 8) | ($urandom_range(0, 1) << 5)
                            | ($urandom_range(0, 1) << 4));
      for (int k = 0; k < int'($urandom_range(8, 12)); k++) begin
        cyc = 0;
        do begin
          peek(4'd2, v);
          if (v[6]) try_pop();
          cyc++;
        end while (v[6] && cyc < 500);
        b = 8'($urandom);
        bus_wr(4'd3, 4'b0001, {24'd0, b});
        exp_q.push_back(b);
        if ($urandom_range(0, 1) == 1) try_pop();
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      cyc = 0;
      do begin
        try_pop();
        peek(4'd2, v);
        cyc++;
      end while ((exp_q.size() != 0 || v[7] || !v[3]) && cyc < 3000);
      check($sformatf("rand round%0d drained", r), exp_q.size(), 0);
      check($sformatf("rand round%0d status", r), v, 32'h0000_0028);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
